// File: rtl/riscv_monitor_pkg.sv
// Shared types for the RISC-V test-completion monitor: FSM states and jump-trace record.
// Trace fields are sized for the widest supported core (XLEN <= 64); narrower cores zero-extend.
package riscv_monitor_pkg;

    localparam int TRACE_XLEN_MAX = 64;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_TIMEOUT
    } mon_state_t;

    typedef struct packed {
        logic [TRACE_XLEN_MAX-1:0] src;
        logic [TRACE_XLEN_MAX-1:0] dst;
    } trace_rec_t;

endpackage

// File: rtl/trace_ring_buffer.sv
// Ring buffer with show-ahead head; a push while full overwrites the oldest entry and sets sticky overflow.
// Head reflects a push or pop one cycle later; never backpressures the writer, and pops while empty are dropped.
module trace_ring_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             pop_ok;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign pop_ok = pop && !empty;
    // Gate with empty so stale storage never leaks onto the read port.
    assign head   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            // On full push+pop the slot freed by the pop receives the new entry.
            if (pop_ok || (push && full)) rd_ptr <= rd_ptr + AW'(1);
            if (push && full && !pop_ok) overflow <= 1'b1;
            if (push && !pop_ok && !full) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/riscv_test_monitor.sv
// Watches writeback for the done/pass signature, enforces a cycle timeout and traces jumps.
// Verdict lands DRAIN_CYCLES+1 cycles after the done write; inputs are never backpressured.
module riscv_test_monitor
    import riscv_monitor_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TRACE_DEPTH    = 16,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int DRAIN_CYCLES   = 3,
    parameter int DONE_REG       = 26,
    parameter int PASS_REG       = 27,
    parameter int TNUM_REG       = 3,
    parameter int CNT_W          = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         wb_en,
    input  logic [4:0]                   wb_addr,
    input  logic [XLEN-1:0]              wb_data,
    input  logic                         retire,
    input  logic [XLEN-1:0]              pc,
    input  logic                         jump,
    input  logic [XLEN-1:0]              jump_addr,
    input  logic                         trace_rd_en,
    output logic [XLEN-1:0]              trace_src,
    output logic [XLEN-1:0]              trace_dst,
    output logic                         trace_empty,
    output logic [$clog2(TRACE_DEPTH):0] trace_count,
    output logic                         trace_overflow,
    output logic                         done,
    output logic                         pass,
    output logic                         timeout,
    output logic [XLEN-1:0]              fail_testnum,
    output logic [CNT_W-1:0]             cycle_count,
    output logic [CNT_W-1:0]             instret_count
);
    localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    mon_state_t      state;
    logic [DW-1:0]   drain_cnt;
    logic [XLEN-1:0] pass_sh;
    logic [XLEN-1:0] tnum_sh;
    logic            active;
    logic            wr_ok;
    logic            done_wr;
    logic            expire;
    trace_rec_t      push_rec;
    trace_rec_t      head_rec;

    assign active   = (state == ST_RUN) || (state == ST_DRAIN);
    assign wr_ok    = active && wb_en && (wb_addr != 5'd0);
    assign done_wr  = wr_ok && (wb_addr == 5'(DONE_REG)) && (wb_data == XLEN'(1));
    assign expire   = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
    assign push_rec = '{src: TRACE_XLEN_MAX'(pc), dst: TRACE_XLEN_MAX'(jump_addr)};

    trace_ring_buffer #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH ($bits(trace_rec_t))
    ) u_trace (
        .clk      (clk),
        .rstn     (rstn),
        .push     (jump && active),
        .push_dat (push_rec),
        .pop      (trace_rd_en),
        .head     (head_rec),
        .empty    (trace_empty),
        .count    (trace_count),
        .overflow (trace_overflow)
    );

    assign trace_src = XLEN'(head_rec.src);
    assign trace_dst = XLEN'(head_rec.dst);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= ST_RUN;
            drain_cnt     <= '0;
            pass_sh       <= '0;
            tnum_sh       <= '0;
            cycle_count   <= '0;
            instret_count <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            fail_testnum  <= '0;
        end else begin
            if (active) begin
                if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
                if (retire && (instret_count != '1)) instret_count <= instret_count + CNT_W'(1);
            end
            if (wr_ok && (wb_addr == 5'(PASS_REG))) pass_sh <= wb_data;
            if (wr_ok && (wb_addr == 5'(TNUM_REG))) tnum_sh <= wb_data;

            case (state)
                ST_RUN: begin
                    // Expiry is checked first so a coincident done write still times out.
                    if (expire) begin
                        state        <= ST_TIMEOUT;
                        done         <= 1'b1;
                        timeout      <= 1'b1;
                        pass         <= 1'b0;
                        fail_testnum <= tnum_sh;
                    end else if (done_wr) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DW'(DRAIN_CYCLES);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state        <= ST_DONE;
                        done         <= 1'b1;
                        pass         <= (pass_sh == XLEN'(1));
                        fail_testnum <= tnum_sh;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor: a table of trace-buffer vectors plus hand-written
// sequences for pass/fail verdicts, timeout races and asynchronous reset during DRAIN.
module tb_riscv_test_monitor;

    logic        clk;
    logic        rstn;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        retire;
    logic [31:0] pc;
    logic        jump;
    logic [31:0] jump_addr;
    logic        trace_rd_en;
    logic [31:0] trace_src;
    logic [31:0] trace_dst;
    logic        trace_empty;
    logic [2:0]  trace_count;
    logic        trace_overflow;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [31:0] fail_testnum;
    logic [31:0] cycle_count;
    logic [31:0] instret_count;

    riscv_test_monitor #(
        .TRACE_DEPTH    (4),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .retire         (retire),
        .pc             (pc),
        .jump           (jump),
        .jump_addr      (jump_addr),
        .trace_rd_en    (trace_rd_en),
        .trace_src      (trace_src),
        .trace_dst      (trace_dst),
        .trace_empty    (trace_empty),
        .trace_count    (trace_count),
        .trace_overflow (trace_overflow),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .fail_testnum   (fail_testnum),
        .cycle_count    (cycle_count),
        .instret_count  (instret_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        rst;
        logic        jmp;
        logic [31:0] src;
        logic        rd;
        logic [2:0]  cnt;
        logic        emp;
        logic        ovf;
        logic [31:0] exp_src;
    } trow_t;

    trow_t tbl[$];

    function automatic trow_t mk(logic rst, logic jmp, logic [31:0] src, logic rd,
                                 logic [2:0] cnt, logic emp, logic ovf, logic [31:0] exp_src);
        trow_t r;
        r.rst = rst; r.jmp = jmp; r.src = src; r.rd = rd;
        r.cnt = cnt; r.emp = emp; r.ovf = ovf; r.exp_src = exp_src;
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wb(int a, int d);
        wb_en   = 1'b1;
        wb_addr = 5'(a);
        wb_data = 32'(d);
        step(1);
        wb_en   = 1'b0;
        wb_addr = '0;
        wb_data = '0;
    endtask

    task automatic chk_idle(string tag);
        chk({tag, ".done"},     done, 0);
        chk({tag, ".pass"},     pass, 0);
        chk({tag, ".timeout"},  timeout, 0);
        chk({tag, ".testnum"},  fail_testnum, 0);
        chk({tag, ".cycles"},   cycle_count, 0);
        chk({tag, ".instret"},  instret_count, 0);
        chk({tag, ".tcount"},   trace_count, 0);
        chk({tag, ".tempty"},   trace_empty, 1);
        chk({tag, ".tovf"},     trace_overflow, 0);
        chk({tag, ".tsrc"},     trace_src, 0);
        chk({tag, ".tdst"},     trace_dst, 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; retire = 1'b0;
        pc = '0; jump = 1'b0; jump_addr = '0; trace_rd_en = 1'b0;
        #2;
        chk_idle("reset");
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; retire = 1'b0;
        pc = '0; jump = 1'b0; jump_addr = '0; trace_rd_en = 1'b0;
        #1;

        // Overflow: six pushes into a depth-4 ring, then drain
        tbl.push_back(mk(1, 1, 'h10, 0, 1, 0, 0, 'h10));
        tbl.push_back(mk(0, 1, 'h20, 0, 2, 0, 0, 'h10));
        tbl.push_back(mk(0, 1, 'h30, 0, 3, 0, 0, 'h10));
        tbl.push_back(mk(0, 1, 'h40, 0, 4, 0, 0, 'h10));
        tbl.push_back(mk(0, 1, 'h50, 0, 4, 0, 1, 'h20));
        tbl.push_back(mk(0, 1, 'h60, 0, 4, 0, 1, 'h30));
        tbl.push_back(mk(0, 0, 'h0,  1, 3, 0, 1, 'h40));
        tbl.push_back(mk(0, 0, 'h0,  1, 2, 0, 1, 'h50));
        tbl.push_back(mk(0, 0, 'h0,  1, 1, 0, 1, 'h60));
        tbl.push_back(mk(0, 0, 'h0,  1, 0, 1, 1, 'h0));
        tbl.push_back(mk(0, 0, 'h0,  1, 0, 1, 1, 'h0));
        // Full push+pop: oldest entry leaves, count stays, no overflow
        tbl.push_back(mk(1, 1, 'hA0, 0, 1, 0, 0, 'hA0));
        tbl.push_back(mk(0, 1, 'hB0, 0, 2, 0, 0, 'hA0));
        tbl.push_back(mk(0, 1, 'hC0, 0, 3, 0, 0, 'hA0));
        tbl.push_back(mk(0, 1, 'hD0, 0, 4, 0, 0, 'hA0));
        tbl.push_back(mk(0, 1, 'hE0, 1, 4, 0, 0, 'hB0));
        tbl.push_back(mk(0, 0, 'h0,  1, 3, 0, 0, 'hC0));
        tbl.push_back(mk(0, 0, 'h0,  1, 2, 0, 0, 'hD0));
        tbl.push_back(mk(0, 0, 'h0,  1, 1, 0, 0, 'hE0));
        tbl.push_back(mk(0, 0, 'h0,  1, 0, 1, 0, 'h0));
        tbl.push_back(mk(0, 1, 'hF0, 0, 1, 0, 0, 'hF0));
        tbl.push_back(mk(0, 1, 'h100, 1, 1, 0, 0, 'h100));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            jump        = tbl[i].jmp;
            pc          = tbl[i].src;
            jump_addr   = tbl[i].src + 32'h100;
            trace_rd_en = tbl[i].rd;
            step(1);
            jump = 1'b0; trace_rd_en = 1'b0;
            chk($sformatf("row%0d.count", i), trace_count, tbl[i].cnt);
            chk($sformatf("row%0d.empty", i), trace_empty, tbl[i].emp);
            chk($sformatf("row%0d.ovf", i),   trace_overflow, tbl[i].ovf);
            chk($sformatf("row%0d.src", i),   trace_src, tbl[i].exp_src);
            chk($sformatf("row%0d.dst", i),   trace_dst,
                (tbl[i].exp_src == 0) ? 32'h0 : tbl[i].exp_src + 32'h100);
        end

        // Pass: x27=1 at edge 1, x26=1 at edge 10, verdict at edge 14
        do_reset();
        retire = 1'b1;
        wb(27, 1);
        jump = 1'b1; pc = 'h80; jump_addr = 'h180; step(1); jump = 1'b0;
        step(3);
        retire = 1'b0;
        step(4);
        wb(26, 1);
        step(3);
        chk("pass.done_early", done, 0);
        chk("pass.cycles13", cycle_count, 13);
        step(1);
        chk("pass.done", done, 1);
        chk("pass.pass", pass, 1);
        chk("pass.timeout", timeout, 0);
        chk("pass.cycles14", cycle_count, 14);
        chk("pass.instret", instret_count, 5);
        step(2);
        chk("pass.cycles_frozen", cycle_count, 14);
        chk("pass.done_held", done, 1);
        chk("pass.tcount", trace_count, 1);
        chk("pass.tsrc", trace_src, 'h80);
        chk("pass.tdst", trace_dst, 'h180);
        jump = 1'b1; pc = 'h90; jump_addr = 'h190; trace_rd_en = 1'b1;
        step(1);
        jump = 1'b0; trace_rd_en = 1'b0;
        chk("pass.pop_in_done", trace_count, 0);
        chk("pass.empty_in_done", trace_empty, 1);

        // Fail: x3=5, x27=0, x26=1 at edge 3
        do_reset();
        wb(3, 5);
        wb(27, 0);
        wb(26, 1);
        step(4);
        chk("fail.done", done, 1);
        chk("fail.pass", pass, 0);
        chk("fail.testnum", fail_testnum, 5);

        // Pass flag written during DRAIN still counts
        do_reset();
        wb(3, 7);
        wb(27, 0);
        wb(26, 1);
        wb(27, 1);
        step(2);
        chk("drainpass.done_early", done, 0);
        step(1);
        chk("drainpass.done", done, 1);
        chk("drainpass.pass", pass, 1);
        chk("drainpass.testnum", fail_testnum, 7);

        // Timeout with no done write
        do_reset();
        step(49);
        chk("to.timeout_early", timeout, 0);
        chk("to.cycles49", cycle_count, 49);
        step(1);
        chk("to.timeout", timeout, 1);
        chk("to.done", done, 1);
        chk("to.pass", pass, 0);
        chk("to.cycles50", cycle_count, 50);
        step(5);
        chk("to.cycles_frozen", cycle_count, 50);
        chk("to.timeout_held", timeout, 1);

        // Done write on the expiry edge: timeout wins even with pass shadow set
        do_reset();
        wb(27, 1);
        step(48);
        wb(26, 1);
        chk("race.timeout", timeout, 1);
        chk("race.done", done, 1);
        chk("race.pass", pass, 0);
        step(4);
        chk("race.cycles", cycle_count, 50);

        // Done write one edge before expiry: DRAIN does not time out
        do_reset();
        wb(27, 1);
        step(47);
        wb(26, 1);
        step(3);
        chk("late.done_early", done, 0);
        chk("late.timeout_early", timeout, 0);
        step(1);
        chk("late.done", done, 1);
        chk("late.timeout", timeout, 0);
        chk("late.pass", pass, 1);
        chk("late.cycles", cycle_count, 53);

        // Asynchronous reset one cycle into DRAIN, then a fresh pass run
        do_reset();
        jump = 1'b1; pc = 'h44; jump_addr = 'h144; step(1); jump = 1'b0;
        wb(26, 1);
        step(1);
        chk("mid.cycles", cycle_count, 3);
        chk("mid.tcount", trace_count, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk_idle("mid_reset");
        @(negedge clk);
        rstn = 1'b1;
        wb(27, 1);
        wb(26, 1);
        step(3);
        chk("again.done_early", done, 0);
        step(1);
        chk("again.done", done, 1);
        chk("again.pass", pass, 1);
        chk("again.cycles", cycle_count, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_test_monitor.md
# riscv_test_monitor

Synthesizable, parametrised test-completion monitor for the RISC-V core. It snoops the register-file writeback port, jump events and retire pulses. It detects the pass/fail signature written by the ISA test programs and enforces a cycle timeout. It also keeps a ring buffer of recent jumps that a host or bench can drain through a show-ahead read port. It sits beside `riscv_soc`, wired to the core's writeback, jump and EX-stage PC signals, and replaces ad-hoc testbench polling.

## Interface
Parameters:
- `XLEN`, 32, data/address width
- `TRACE_DEPTH`, 16, jump-trace entries; power of two, ≥2
- `TIMEOUT_CYCLES`, 1000, run cycles before timeout; ≥1
- `DRAIN_CYCLES`, 3, cycles waited after the done flag before the verdict is sampled
- `DONE_REG`, 26, GPR index of the done flag
- `PASS_REG`, 27, GPR index of the pass flag
- `TNUM_REG`, 3, GPR index of the test number
- `CNT_W`, 32, width of the cycle and instret counters

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock
- `rstn` in 1: asynchronous active-low reset
- `wb_en` in 1: register write strobe
- `wb_addr` in 5: destination GPR
- `wb_data` in XLEN: write data
- `retire` in 1: one instruction retired this cycle
- `pc` in XLEN: PC of the instruction in EX
- `jump` in 1: taken jump/branch this cycle
- `jump_addr` in XLEN: jump target
- `trace_rd_en` in 1: pop the head trace entry
- `trace_src` out XLEN: head entry source PC (show-ahead)
- `trace_dst` out XLEN: head entry target
- `trace_empty` out 1: trace buffer empty
- `trace_count` out $clog2(TRACE_DEPTH)+1: number of valid entries
- `trace_overflow` out 1: sticky; at least one entry was overwritten
- `done` out 1: verdict valid
- `pass` out 1: test passed
- `timeout` out 1: ended by timeout
- `fail_testnum` out XLEN: shadow of `TNUM_REG` at verdict time
- `cycle_count` out CNT_W: cycles spent in RUN+DRAIN; saturating
- `instret_count` out CNT_W: retires counted in RUN+DRAIN; saturating

## Operation
- FSM states: RUN, DRAIN, DONE, TIMEOUT. Reset enters RUN.
- Shadow registers for DONE_REG, PASS_REG and TNUM_REG load on `wb_en` when `wb_addr` matches. Writes with `wb_addr`=0 are ignored. Shadows keep updating in DRAIN and freeze in DONE/TIMEOUT.
- RUN → DRAIN when `wb_en` writes value 1 to DONE_REG. The drain counter loads DRAIN_CYCLES.
- RUN → TIMEOUT when `cycle_count` reaches TIMEOUT_CYCLES−1 without a done write. If the done write and the expiry occur in the same cycle, TIMEOUT wins.
- DRAIN does not time out. DRAIN → DONE when the drain counter reaches 0. At that point `pass` = (PASS shadow == 1) and `fail_testnum` is loaded from the TNUM shadow.
- In TIMEOUT: `done`=1, `timeout`=1, `pass`=0.
- DONE and TIMEOUT are terminal until reset.
- `cycle_count` increments every cycle in RUN/DRAIN. `instret_count` increments on `retire` in RUN/DRAIN. Both saturate at all-ones.
- Trace push happens on `jump` in RUN/DRAIN and records {`pc`, `jump_addr`}.
- Push while full overwrites the oldest entry: read pointer advances, count is unchanged, `trace_overflow` is set.
- Pop on `trace_rd_en` && !`trace_empty`. A pop while empty is ignored.
- Push and pop in the same cycle: count is unchanged, no overflow. This holds when full too: the popped entry is the pre-push head.
- Trace reads remain allowed in DONE/TIMEOUT.

## Timing
- Reset values: all outputs 0 and `trace_empty`=1. Pointers, shadows and counters are 0.
- Shadow update lands one cycle after `wb_en`.
- `done` rises exactly DRAIN_CYCLES+1 cycles after the clock edge that samples the DONE_REG=1 write.
- `timeout` rises on the edge where `cycle_count` would reach TIMEOUT_CYCLES.
- Trace outputs are registered-pointer show-ahead. The new head is visible the cycle after a pop. A push into an empty buffer is visible the next cycle.
- Pointers wrap modulo TRACE_DEPTH with no special case.
- Reset asserted mid-DRAIN or mid-TIMEOUT returns everything to reset values immediately (asynchronously).

## Structure
- Package `riscv_monitor_pkg` holds:
  - the FSM state enum (RUN/DRAIN/DONE/TIMEOUT);
  - the trace record struct {src, dst}.
- One sub-module, `trace_ring_buffer`: parametrised by depth and record width, with overwrite-on-full and sticky overflow.
- The FSM, shadows and counters stay in the top module.

## Test plan
- Pass: write x27=1, then x26=1 at cycle 10 → `done`=1 at cycle 14, `pass`=1, `timeout`=0.
- Fail: write x3=5, x27=0, x26=1 → `done`=1, `pass`=0, `fail_testnum`=5. Also write x27=1 during DRAIN → `pass`=1.
- Timeout: TIMEOUT_CYCLES=50, no done write → `timeout`=1 after 50 cycles, `cycle_count`=50 frozen. A done write landing on the expiry cycle still gives `timeout`=1.
- Overflow: TRACE_DEPTH=4, jumps with pc 0x10,0x20,…,0x60 → `trace_count`=4, `trace_overflow`=1, pops yield src 0x30,0x40,0x50,0x60, then `trace_empty`=1.
- Full push+pop: buffer full, jump and `trace_rd_en` in the same cycle → popped head is the old oldest entry, `trace_count` stays 4, `trace_overflow` stays 0.
- Reset mid-DRAIN: drop `rstn` 1 cycle after the done write → all outputs 0 and `trace_empty`=1. After release, a fresh pass sequence completes normally.
